code_entry_tracker: RTL and testbench
=====================================

CODE_ENTRY_TRACKER -- requirements
Module: code_entry_tracker

Interface
REQ-001 Parameter NUM_DIGITS, default 4, SHALL set the digits per code (legal range 2..16).
REQ-002 Parameter DIGIT_W, default 4, SHALL set the bits per digit.
REQ-003 Parameter TIMEOUT_TICKS, default 250, SHALL set the inter-entry timeout in tick_i pulses; 0 SHALL disable the timeout.
REQ-004 clk_i  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 entry_i  input  1  SHALL be the key-press level; only its rising edge counts.
REQ-007 digit_i  input  DIGIT_W  SHALL be the digit value, sampled on the accepting cycle.
REQ-008 backspace_i  input  1  SHALL be a single-cycle strobe that removes the last digit.
REQ-009 clear_i  input  1  SHALL be a single-cycle strobe that abandons the entry.
REQ-010 tick_i  input  1  SHALL be a single-cycle timebase strobe for the timeout.
REQ-011 digit_idx_o  output  clog2(NUM_DIGITS)  SHALL be the number of digits currently stored.
REQ-012 entering_last_digit_o  output  1  SHALL be high while exactly NUM_DIGITS-1 digits are stored.
REQ-013 code_valid_o  output  1  SHALL be a one-cycle pulse when a full code is complete.
REQ-014 code_o  output  NUM_DIGITS*DIGIT_W  SHALL present the stored digits, first digit in the most significant slot.
REQ-015 timeout_o  output  1  SHALL be a one-cycle pulse when an entry is abandoned by timeout.

Function
REQ-016 The block SHALL accept an entry in a cycle where entry_i=1 and the registered previous entry_i=0; holding entry_i high SHALL produce exactly one entry.
REQ-017 The FSM states SHALL be IDLE (0 digits), ENTERING (1..NUM_DIGITS-1 digits) and DONE.
- IDLE -> ENTERING on an accepted entry.
- ENTERING -> DONE on the accepted entry that makes NUM_DIGITS.
- DONE -> IDLE unconditionally after one cycle.
REQ-018 An accepted entry k (0-based) SHALL write digit_i into code_o[(NUM_DIGITS-1-k)*DIGIT_W +: DIGIT_W].
REQ-019 The first accepted entry from IDLE SHALL zero all other slots of code_o in the same update.
REQ-020 All outputs SHALL be registered and reflect an accepted event on the cycle after it.
REQ-021 code_valid_o SHALL be 1 exactly while in DONE; in DONE, digit_idx_o SHALL read 0 and entering_last_digit_o SHALL read 0.
REQ-022 code_o SHALL hold the completed code after DONE until the next accepted entry or clear.
REQ-023 An entry edge in DONE SHALL be accepted as the first digit of a new code (IDLE behaviour).
REQ-024 Backspace in ENTERING SHALL decrement the count and zero the removed slot; from 1 digit it SHALL return to IDLE.
REQ-025 Backspace in IDLE or DONE SHALL be ignored.
REQ-026 Clear SHALL force IDLE, count 0 and code_o 0 from any state.
REQ-027 Priority in one cycle SHALL be clear > backspace > entry; a lower-priority event SHALL be discarded, but the edge-detect register SHALL still update.
REQ-028 The timeout counter SHALL:
- reset to 0 on every accepted entry or backspace;
- count tick_i pulses only in ENTERING.
REQ-029 When the timeout counter reaches TIMEOUT_TICKS (nonzero), the block SHALL go to IDLE, zero the count and code_o, and pulse timeout_o for one cycle.
REQ-030 A timeout coinciding with an accepted entry SHALL lose to the entry.

Reset
REQ-031 Asserting rst_ni=0 SHALL immediately (asynchronously) force the following, including mid-entry:
- state IDLE;
- digit_idx_o=0;
- entering_last_digit_o=0, code_valid_o=0, timeout_o=0;
- code_o=0;
- timeout counter 0;
- edge-detect register 0.
REQ-032 An entry_i already high when rst_ni releases SHALL count as a rising edge on the first clock.

Verification
REQ-033 The bench SHALL run the following directed scenarios (NUM_DIGITS=4, DIGIT_W=4):
- Six 1-cycle entry strobes with digits 1..6, one low cycle between each -> entering_last_digit_o=1 after the 3rd; code_valid_o one pulse after the 4th with code_o=16'h1234; after the 6th, digit_idx_o=2 and code_o=16'h5600.
- entry_i held high for 5 cycles with digit 7 -> digit_idx_o=1, code_o=16'h7000.
- Entries 1,2,3, then backspace, then entry 9 -> code_o=16'h1290, digit_idx_o=3.
- TIMEOUT_TICKS=3; entries 1,2, then 3 tick_i pulses -> timeout_o one pulse, digit_idx_o=0, code_o=0.
- clear_i and an entry edge in the same cycle with 2 digits stored -> digit_idx_o=0, code_o=0, no digit stored.
- rst_ni low mid-entry with 3 digits stored -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/code_entry_tracker_if.sv
// -----------------------------------------------------------------------------
// code_entry_tracker_if
// Bundles the keypad-side strobes and the tracker status outputs of
// code_entry_tracker.
//   master : keypad/controller side (drives entry/digit/backspace/clear/tick)
//   slave  : tracker side (drives digit_idx/entering_last_digit/code_valid/
//            code/timeout)
// NUM_DIGITS and DIGIT_W must match the parameters of the attached tracker.
// -----------------------------------------------------------------------------
interface code_entry_tracker_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CODE_W = NUM_DIGITS * DIGIT_W;

    logic                 entry_i;
    logic [DIGIT_W-1:0]   digit_i;
    logic                 backspace_i;
    logic                 clear_i;
    logic                 tick_i;
    logic [IDX_W-1:0]     digit_idx_o;
    logic                 entering_last_digit_o;
    logic                 code_valid_o;
    logic [CODE_W-1:0]    code_o;
    logic                 timeout_o;

    modport master (
        output entry_i, digit_i, backspace_i, clear_i, tick_i,
        input  digit_idx_o, entering_last_digit_o, code_valid_o, code_o, timeout_o
    );

    modport slave (
        input  entry_i, digit_i, backspace_i, clear_i, tick_i,
        output digit_idx_o, entering_last_digit_o, code_valid_o, code_o, timeout_o
    );
endinterface

// File: rtl/code_entry_tracker.sv
// -----------------------------------------------------------------------------
// code_entry_tracker
// Collects NUM_DIGITS keypad digits into a code word, supporting backspace,
// clear and an inter-entry timeout counted in tick_i pulses.
// Ports:
//   clk_i   : clock, all state changes on the rising edge
//   rst_ni  : asynchronous active-low reset
//   bus     : code_entry_tracker_if.slave
//             in : entry_i (key level, rising edge accepted), digit_i,
//                  backspace_i, clear_i, tick_i (single-cycle strobes)
//             out: digit_idx_o (digits stored), entering_last_digit_o,
//                  code_valid_o (one-cycle pulse), code_o (first digit in MS
//                  slot), timeout_o (one-cycle pulse)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module code_entry_tracker #(
    parameter int NUM_DIGITS    = 4,
    parameter int DIGIT_W       = 4,
    parameter int TIMEOUT_TICKS = 250
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    code_entry_tracker_if.slave    bus
);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int TMO_W  = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_TICKS != 0);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] ONE_IDX   = IDX_W'(1);
    localparam logic [TMO_W:0]   TMO_LIMIT = (TMO_W + 1)'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ENTERING = 2'd1,
        DONE     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    count_q, count_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                entry_prev_q;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                timeout_q, timeout_d;
    logic                accept_s;
    logic [TMO_W:0]      tmo_inc_s;

    // Returns code with slot k (0 = most significant) replaced by d.
    function automatic logic [CODE_W-1:0] put_digit(
        input logic [CODE_W-1:0]  code,
        input logic [IDX_W-1:0]   k,
        input logic [DIGIT_W-1:0] d
    );
        logic [CODE_W-1:0] r;
        r = code;
        for (int s = 0; s < NUM_DIGITS; s++) begin
            if (k == IDX_W'(s)) begin
                r[(NUM_DIGITS-1-s)*DIGIT_W +: DIGIT_W] = d;
            end
        end
        return r;
    endfunction

    // Rising-edge detect on the key level and timeout counter increment.
    assign accept_s  = bus.entry_i & ~entry_prev_q;
    assign tmo_inc_s = {1'b0, tmo_q} + {{TMO_W{1'b0}}, 1'b1};

    // Next-state logic: clear beats backspace beats entry beats timeout.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        code_d    = code_q;
        tmo_d     = tmo_q;
        timeout_d = 1'b0;

        if (bus.clear_i) begin
            state_d = IDLE;
            count_d = '0;
            code_d  = '0;
            tmo_d   = '0;
        end else if (bus.backspace_i) begin
            // A backspace outside ENTERING does nothing to the code, but it
            // still swallows a same-cycle entry and ends a DONE cycle.
            if (state_q == ENTERING) begin
                count_d = count_q - ONE_IDX;
                code_d  = put_digit(code_q, count_q - ONE_IDX, '0);
                tmo_d   = '0;
                if (count_q == ONE_IDX) begin
                    state_d = IDLE;
                end else begin
                    state_d = ENTERING;
                end
            end else begin
                state_d = IDLE;
            end
        end else if (accept_s) begin
            tmo_d = '0;
            if (state_q == ENTERING) begin
                code_d = put_digit(code_q, count_q, bus.digit_i);
                if (count_q == LAST_IDX) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    state_d = ENTERING;
                    count_d = count_q + ONE_IDX;
                end
            end else begin
                // First digit of a new code wipes whatever code was held.
                code_d  = put_digit('0, '0, bus.digit_i);
                state_d = ENTERING;
                count_d = ONE_IDX;
            end
        end else if (state_q == ENTERING) begin
            if (TMO_EN && bus.tick_i) begin
                if (tmo_inc_s == TMO_LIMIT) begin
                    state_d   = IDLE;
                    count_d   = '0;
                    code_d    = '0;
                    tmo_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_inc_s[TMO_W-1:0];
                end
            end else begin
                tmo_d = tmo_q;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else begin
            state_d = state_q;
        end

        valid_d = (state_d == DONE);
        last_d  = (state_d == ENTERING) && (count_d == LAST_IDX);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            count_q      <= '0;
            code_q       <= '0;
            tmo_q        <= '0;
            entry_prev_q <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            code_q       <= code_d;
            tmo_q        <= tmo_d;
            entry_prev_q <= bus.entry_i;
            valid_q      <= valid_d;
            last_q       <= last_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.digit_idx_o           = count_q;
    assign bus.entering_last_digit_o = last_q;
    assign bus.code_valid_o          = valid_q;
    assign bus.code_o                = code_q;
    assign bus.timeout_o             = timeout_q;

endmodule

// File: tb/tb_code_entry_tracker.sv
// -----------------------------------------------------------------------------
// tb_code_entry_tracker
// Directed scoreboard bench for code_entry_tracker (4 digits x 4 bits,
// timeout after 3 ticks). Each stimulus cycle pushes the outputs expected after
// the next rising edge; a monitor pops and compares them 1 ns after that edge.
// Expected vector layout: {digit_idx[1:0], last, valid, timeout, code[15:0]}.
// -----------------------------------------------------------------------------
module tb_code_entry_tracker;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   step_no;
    string scen;
    exp_t exp_q[$];

    code_entry_tracker_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

    code_entry_tracker #(
        .NUM_DIGITS    (4),
        .DIGIT_W       (4),
        .TIMEOUT_TICKS (3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [20:0] outs();
        return {bus.digit_idx_o, bus.entering_last_digit_o, bus.code_valid_o,
                bus.timeout_o, bus.code_o};
    endfunction

    // Scoreboard monitor: compare outputs after each rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, {11'd0, outs()}, {11'd0, e.v});
        end
    end

    // Drive one cycle of inputs (called at a falling edge) and queue the
    // outputs expected after the following rising edge.
    task automatic step(input logic ent, input logic [3:0] dig, input logic bs,
                        input logic clr, input logic tk,
                        input logic [1:0] idx, input logic last, input logic val,
                        input logic to, input logic [15:0] code);
        exp_t e;
        bus.entry_i     = ent;
        bus.digit_i     = dig;
        bus.backspace_i = bs;
        bus.clear_i     = clr;
        bus.tick_i      = tk;
        e.tag = $sformatf("%s#%0d", scen, step_no);
        e.v   = {idx, last, val, to, code};
        step_no++;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        step_no  = 0;
        scen     = "reset";
        rst_n           = 1'b0;
        bus.entry_i     = 1'b0;
        bus.digit_i     = 4'd0;
        bus.backspace_i = 1'b0;
        bus.clear_i     = 1'b0;
        bus.tick_i      = 1'b0;
        #1;
        chk("reset_outs", {11'd0, outs()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Six strobes 1..6 with a low cycle between each.
        scen = "six";
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1230);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1230);
        step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 16'h1234);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h1234);
        step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h5000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h5000);
        step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h5600);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h5600);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Entry level held high for 5 cycles: exactly one digit.
        scen = "held";
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h7000);
        end
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h7000);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Backspace removes the third digit; 9 takes its slot.
        scen = "bksp";
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1230);
        step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1290);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Three ticks after the last entry abandon the code.
        scen = "tmo";
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Entries restart the tick count; an entry beats a coinciding timeout.
        scen = "tmo_rst";
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1230);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1230);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1230);
        step(1'b1, 4'd4, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 16'h1234);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h1234);
        step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Clear and entry edge together: clear wins, edge is still consumed.
        scen = "clr_ent";
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b1, 4'd5, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

        // Asynchronous reset with three digits stored.
        scen = "async_rst";
        step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h1000);
        step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 16'h1200);
        step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 16'h1230);
        rst_n = 1'b0;
        #1;
        chk("async_rst_outs", {11'd0, outs()}, 32'd0);
        // Key already pressed while reset releases: first clock takes it.
        bus.entry_i = 1'b1;
        bus.digit_i = 4'd8;
        @(negedge clk);
        rst_n = 1'b1;
        scen = "rst_edge";
        step(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h8000);
        step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 16'h8000);

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
